// File: rtl/id_ex_stage_pkg.sv
// Shared CPU definitions used by the ID/EX pipeline register and the ALU control stage.
package id_ex_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int CNT_W      = 16;
  localparam int REG_ADDR_W = 5;
  localparam int FUNCT_W    = 4;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } alu_op_e;

  typedef struct packed {
    alu_op_e              alu_op;
    logic [FUNCT_W-1:0]   funct;
    logic                 alu_src;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic                 branch;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     rs1_data;
    logic [DATA_W-1:0]     rs2_data;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
  } data_t;

  typedef struct packed {
    data_t dat;
    ctrl_t ctrl;
  } id_ex_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side operands/controls, pipeline commands and the registered EX-side view.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic                  id_valid_i;
  logic [DATA_W-1:0]     pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [REG_ADDR_W-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [FUNCT_W-1:0]    funct_i;
  logic [1:0]            ALUOp_i;
  logic                  ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, Branch_i;
  logic                  flush_i, stall_i;

  logic                  valid_o;
  logic [DATA_W-1:0]     pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [REG_ADDR_W-1:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [FUNCT_W-1:0]    funct_o;
  logic [1:0]            ALUOp_o;
  logic                  ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, Branch_o;
  logic                  load_use_o;
  logic [CNT_W-1:0]      bubble_cnt_o;

  modport master (
    output id_valid_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
           rs1_addr_i, rs2_addr_i, rd_addr_i, funct_i, ALUOp_i,
           ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, Branch_i,
           flush_i, stall_i,
    input  valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o,
           rs1_addr_o, rs2_addr_o, rd_addr_o, funct_o, ALUOp_o,
           ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, Branch_o,
           load_use_o, bubble_cnt_o
  );

  modport slave (
    input  id_valid_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
           rs1_addr_i, rs2_addr_i, rd_addr_i, funct_i, ALUOp_i,
           ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, Branch_i,
           flush_i, stall_i,
    output valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o,
           rs1_addr_o, rs2_addr_o, rd_addr_o, funct_o, ALUOp_o,
           ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, Branch_o,
           load_use_o, bubble_cnt_o
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use detector: a load in EX whose destination is a source of the ID instruction.
// Purely combinational; x0 never creates a dependency.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic                  i_ex_valid,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
  output logic                  o_load_use
);

  logic w_rd_nonzero;
  logic w_src_match;

  assign w_rd_nonzero = (i_ex_rd_addr != '0);
  assign w_src_match  = (i_ex_rd_addr == i_id_rs1_addr) || (i_ex_rd_addr == i_id_rs2_addr);
  assign o_load_use   = i_ex_valid && i_ex_mem_read && i_id_valid && w_rd_nonzero && w_src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register, 1-cycle latency. Priority per edge: flush > stall > load-use bubble > capture.
// Bubbles (flush or load-use, not under stall) are counted in a saturating counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  id_ex_stage_if.slave bus
);

  id_ex_t           w_id;
  id_ex_t           w_next;
  id_ex_t           r_ex;
  logic             w_next_valid;
  logic             r_valid;
  logic             w_load_use;
  logic             w_bubble;
  logic [CNT_W-1:0] r_bubble_cnt;

  always_comb begin
    w_id                 = '0;
    w_id.dat.pc          = bus.pc_i;
    w_id.dat.rs1_data    = bus.rs1_data_i;
    w_id.dat.rs2_data    = bus.rs2_data_i;
    w_id.dat.imm         = bus.imm_i;
    w_id.dat.rs1_addr    = bus.rs1_addr_i;
    w_id.dat.rs2_addr    = bus.rs2_addr_i;
    w_id.dat.rd_addr     = bus.rd_addr_i;
    w_id.ctrl.alu_op     = alu_op_e'(bus.ALUOp_i);
    w_id.ctrl.funct      = bus.funct_i;
    w_id.ctrl.alu_src    = bus.ALUSrc_i;
    w_id.ctrl.reg_write  = bus.RegWrite_i;
    w_id.ctrl.mem_read   = bus.MemRead_i;
    w_id.ctrl.mem_write  = bus.MemWrite_i;
    w_id.ctrl.mem_to_reg = bus.MemtoReg_i;
    w_id.ctrl.branch     = bus.Branch_i;
  end

  hazard_detect u_hazard_detect (
    .i_ex_valid    (r_valid),
    .i_ex_mem_read (r_ex.ctrl.mem_read),
    .i_ex_rd_addr  (r_ex.dat.rd_addr),
    .i_id_valid    (bus.id_valid_i),
    .i_id_rs1_addr (bus.rs1_addr_i),
    .i_id_rs2_addr (bus.rs2_addr_i),
    .o_load_use    (w_load_use)
  );

  // A flush under stall still clears the register but is not counted as a bubble.
  always_comb begin
    w_next       = r_ex;
    w_next_valid = r_valid;
    w_bubble     = 1'b0;
    if (bus.flush_i) begin
      w_next       = '0;
      w_next_valid = 1'b0;
      w_bubble     = !bus.stall_i;
    end else if (!bus.stall_i) begin
      if (w_load_use) begin
        w_next       = '0;
        w_next_valid = 1'b0;
        w_bubble     = 1'b1;
      end else begin
        w_next       = w_id;
        w_next_valid = bus.id_valid_i;
        if (!bus.id_valid_i) begin
          w_next.ctrl = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ex         <= '0;
      r_valid      <= 1'b0;
      r_bubble_cnt <= '0;
    end else begin
      r_ex    <= w_next;
      r_valid <= w_next_valid;
      if (w_bubble) begin
        r_bubble_cnt <= sat_inc(r_bubble_cnt);
      end
    end
  end

  assign bus.valid_o      = r_valid;
  assign bus.pc_o         = r_ex.dat.pc;
  assign bus.rs1_data_o   = r_ex.dat.rs1_data;
  assign bus.rs2_data_o   = r_ex.dat.rs2_data;
  assign bus.imm_o        = r_ex.dat.imm;
  assign bus.rs1_addr_o   = r_ex.dat.rs1_addr;
  assign bus.rs2_addr_o   = r_ex.dat.rs2_addr;
  assign bus.rd_addr_o    = r_ex.dat.rd_addr;
  assign bus.funct_o      = r_ex.ctrl.funct;
  assign bus.ALUOp_o      = r_ex.ctrl.alu_op;
  assign bus.ALUSrc_o     = r_ex.ctrl.alu_src;
  assign bus.RegWrite_o   = r_ex.ctrl.reg_write;
  assign bus.MemRead_o    = r_ex.ctrl.mem_read;
  assign bus.MemWrite_o   = r_ex.ctrl.mem_write;
  assign bus.MemtoReg_o   = r_ex.ctrl.mem_to_reg;
  assign bus.Branch_o     = r_ex.ctrl.branch;
  assign bus.load_use_o   = w_load_use;
  assign bus.bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: captured instructions go through a scoreboard queue,
// bubbles, hazards, reset and counter behaviour are checked directly.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rd;
    logic [3:0]  funct;
    logic [1:0]  aluop;
    logic [5:0]  ctl;   // {ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg, Branch}
  } rec_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  id_ex_stage_if bus();

  id_ex_stage dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int   n_tests = 0;
  int   n_fail  = 0;
  rec_t exp_q[$];
  logic held;

  function automatic rec_t mk(input logic [31:0] pc, input logic [4:0] rs1a, input logic [4:0] rs2a,
                              input logic [4:0] rd, input logic [31:0] imm, input logic [3:0] funct,
                              input logic [1:0] aluop, input logic [5:0] ctl);
    rec_t r;
    r.pc    = pc;
    r.rs1d  = {16'hA000, pc[15:0]};
    r.rs2d  = {16'hB000, pc[15:0]};
    r.imm   = imm;
    r.rs1a  = rs1a;
    r.rs2a  = rs2a;
    r.rd    = rd;
    r.funct = funct;
    r.aluop = aluop;
    r.ctl   = ctl;
    return r;
  endfunction

  function automatic rec_t outs();
    rec_t r;
    r.pc    = bus.pc_o;
    r.rs1d  = bus.rs1_data_o;
    r.rs2d  = bus.rs2_data_o;
    r.imm   = bus.imm_o;
    r.rs1a  = bus.rs1_addr_o;
    r.rs2a  = bus.rs2_addr_o;
    r.rd    = bus.rd_addr_o;
    r.funct = bus.funct_o;
    r.aluop = bus.ALUOp_o;
    r.ctl   = {bus.ALUSrc_o, bus.RegWrite_o, bus.MemRead_o, bus.MemWrite_o, bus.MemtoReg_o, bus.Branch_o};
    return r;
  endfunction

  task automatic drive(input rec_t r, input logic v);
    bus.id_valid_i = v;
    bus.pc_i       = r.pc;
    bus.rs1_data_i = r.rs1d;
    bus.rs2_data_i = r.rs2d;
    bus.imm_i      = r.imm;
    bus.rs1_addr_i = r.rs1a;
    bus.rs2_addr_i = r.rs2a;
    bus.rd_addr_i  = r.rd;
    bus.funct_i    = r.funct;
    bus.ALUOp_i    = r.aluop;
    {bus.ALUSrc_i, bus.RegWrite_i, bus.MemRead_i, bus.MemWrite_i, bus.MemtoReg_i, bus.Branch_i} = r.ctl;
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every fresh valid output (not one held over by a stall) must match the queue head.
  always @(posedge clk_i) begin
    rec_t got;
    rec_t want;
    held = bus.stall_i;
    #1;
    if (rst_i && bus.valid_o && !held) begin
      n_tests++;
      got = outs();
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL mon_unexpected: got output pc=%0h with no instruction expected", got.pc);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL mon_fields: got %0h expected %0h", got, want);
        end
      end
    end
  end

  initial begin
    rec_t rA, rL, rC, rZ, rX, rN, rD, rE, rF, rG, rH, r0;
    r0 = '0;
    bus.flush_i = 1'b0;
    bus.stall_i = 1'b0;
    drive(r0, 1'b0);

    #2;
    check("rst_valid", bus.valid_o, 0);
    check("rst_cnt", bus.bubble_cnt_o, 0);
    check("rst_load_use", bus.load_use_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Plain R-type capture
    rA = mk(32'h100, 5'd1, 5'd2, 5'd5, 32'h0, 4'b0111, 2'b10, 6'b010000);
    drive(rA, 1'b1); exp_q.push_back(rA); step();
    check("cap_funct", bus.funct_o, 4'b0111);
    check("cap_aluop", bus.ALUOp_o, 2'b10);
    check("cap_rd", bus.rd_addr_o, 5);
    check("cap_valid", bus.valid_o, 1);

    // lw x5 followed by a consumer of x5
    rL = mk(32'h104, 5'd2, 5'd0, 5'd5, 32'h8, 4'b0010, 2'b00, 6'b111010);
    drive(rL, 1'b1); exp_q.push_back(rL); step();
    rC = mk(32'h108, 5'd5, 5'd3, 5'd6, 32'h0, 4'b0000, 2'b10, 6'b010000);
    drive(rC, 1'b1); #1;
    check("lu_detect", bus.load_use_o, 1);
    step();
    check("lu_bubble_valid", bus.valid_o, 0);
    check("lu_bubble_memread", bus.MemRead_o, 0);
    check("lu_bubble_regwrite", bus.RegWrite_o, 0);
    check("lu_bubble_cnt", bus.bubble_cnt_o, 1);
    check("lu_cleared", bus.load_use_o, 0);
    exp_q.push_back(rC); step();

    // Load into x0 never stalls
    rZ = mk(32'h10C, 5'd2, 5'd0, 5'd0, 32'h4, 4'b0010, 2'b00, 6'b111010);
    drive(rZ, 1'b1); exp_q.push_back(rZ); step();
    rX = mk(32'h110, 5'd0, 5'd0, 5'd7, 32'h0, 4'b1000, 2'b10, 6'b010000);
    drive(rX, 1'b1); #1;
    check("x0_no_hazard", bus.load_use_o, 0);
    exp_q.push_back(rX); step();
    check("x0_captured_pc", bus.pc_o, 32'h110);

    // Invalid ID slot: data captured, controls cleared, no bubble counted
    rN = mk(32'h200, 5'd1, 5'd2, 5'd3, 32'h44, 4'b0101, 2'b11, 6'b110101);
    drive(rN, 1'b0); step();
    check("inv_valid", bus.valid_o, 0);
    check("inv_ctl", {bus.ALUSrc_o, bus.RegWrite_o, bus.MemRead_o, bus.MemWrite_o, bus.MemtoReg_o, bus.Branch_o}, 0);
    check("inv_funct_aluop", {bus.funct_o, bus.ALUOp_o}, 0);
    check("inv_pc", bus.pc_o, 32'h200);
    check("inv_cnt", bus.bubble_cnt_o, 1);

    // Load-use held under stall: no count while held, counted once released
    rD = mk(32'h300, 5'd4, 5'd0, 5'd9, 32'h0, 4'b0010, 2'b00, 6'b111010);
    drive(rD, 1'b1); exp_q.push_back(rD); step();
    rE = mk(32'h304, 5'd9, 5'd1, 5'd10, 32'h0, 4'b0000, 2'b10, 6'b010000);
    drive(rE, 1'b1); bus.stall_i = 1'b1; #1;
    check("stall_lu_detect", bus.load_use_o, 1);
    step();
    check("stall_hold_pc", bus.pc_o, 32'h300);
    check("stall_hold_valid", bus.valid_o, 1);
    check("stall_hold_rd", bus.rd_addr_o, 9);
    check("stall_hold_memread", bus.MemRead_o, 1);
    check("stall_hold_cnt", bus.bubble_cnt_o, 1);
    check("stall_lu_still", bus.load_use_o, 1);
    step();
    check("stall_hold2_pc", bus.pc_o, 32'h300);
    check("stall_hold2_cnt", bus.bubble_cnt_o, 1);
    bus.stall_i = 1'b0; step();
    check("release_bubble_valid", bus.valid_o, 0);
    check("release_bubble_cnt", bus.bubble_cnt_o, 2);
    exp_q.push_back(rE); step();

    // Flush beats stall; flush alone counts
    rF = mk(32'h400, 5'd1, 5'd2, 5'd11, 32'h0, 4'b0000, 2'b10, 6'b010000);
    drive(rF, 1'b1); exp_q.push_back(rF); step();
    bus.flush_i = 1'b1; bus.stall_i = 1'b1; step();
    check("fs_valid", bus.valid_o, 0);
    check("fs_regwrite", bus.RegWrite_o, 0);
    check("fs_pc", bus.pc_o, 0);
    check("fs_cnt", bus.bubble_cnt_o, 2);
    bus.stall_i = 1'b0; step();
    check("flush_cnt", bus.bubble_cnt_o, 3);
    bus.flush_i = 1'b0;

    // Asynchronous reset between edges while an instruction is held
    rG = mk(32'h500, 5'd1, 5'd2, 5'd12, 32'h0, 4'b0000, 2'b10, 6'b010000);
    drive(rG, 1'b1); exp_q.push_back(rG);
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    #1;
    check("arst_valid", bus.valid_o, 0);
    check("arst_cnt", bus.bubble_cnt_o, 0);
    check("arst_pc", bus.pc_o, 0);
    @(negedge clk_i);
    rH = mk(32'h600, 5'd3, 5'd4, 5'd13, 32'h0, 4'b0000, 2'b10, 6'b010000);
    drive(rH, 1'b1); bus.stall_i = 1'b1; rst_i = 1'b1;
    step();
    check("post_rst_stall_valid", bus.valid_o, 0);
    check("post_rst_load_use", bus.load_use_o, 0);
    bus.stall_i = 1'b0; exp_q.push_back(rH); step();

    // Counter saturation
    drive(r0, 1'b0); bus.flush_i = 1'b1;
    repeat (65534) @(posedge clk_i);
    @(negedge clk_i);
    check("sat_fffe", bus.bubble_cnt_o, 16'hFFFE);
    step();
    check("sat_ffff", bus.bubble_cnt_o, 16'hFFFF);
    step();
    check("sat_hold", bus.bubble_cnt_o, 16'hFFFF);
    bus.flush_i = 1'b0;
    step();

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
- REQ-001: DATA_W, 32, width of PC, register-data and immediate fields.
- REQ-002: CNT_W, 16, width of the bubble counter.
- REQ-003: clk_i  input  1  single clock; all state updates on rising edge.
- REQ-004: rst_i  input  1  reset, asynchronous, active-low.
- REQ-005: id_valid_i  input  1  ID stage holds a valid instruction.
- REQ-006: pc_i, rs1_data_i, rs2_data_i, imm_i  input  DATA_W each  ID operands.
- REQ-007: rs1_addr_i, rs2_addr_i, rd_addr_i  input  5 each  register addresses.
- REQ-008: funct_i  input  4  {funct7[5], funct3} for the ALU control stage.
- REQ-009: ALUOp_i  input  2  ALU operation class.
- REQ-010: ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, Branch_i  input  1 each  decoded controls.
- REQ-011: flush_i  input  1  squash (taken branch); stall_i  input  1  downstream hold.
- REQ-012: Registered copies of every REQ-006..REQ-010 field, suffixed _o; valid_o  output  1.
- REQ-013: load_use_o  output  1  combinational; upstream (PC, IF/ID) must hold this cycle.
- REQ-014: bubble_cnt_o  output  CNT_W  count of bubbles inserted.

Function
- REQ-015: load_use_o SHALL be 1 iff valid_o & MemRead_o & id_valid_i & rd_addr_o != 0 & (rd_addr_o == rs1_addr_i | rd_addr_o == rs2_addr_i), else 0.
- REQ-016: Per rising edge, priority: flush_i > stall_i > load_use_o > capture.
- REQ-017: flush_i=1: next valid_o=0 and all _o fields 0, regardless of stall_i.
- REQ-018: stall_i=1 (no flush): all _o registers and bubble_cnt_o hold.
- REQ-019: load_use_o=1 (no flush/stall): bubble inserted -- valid_o=0, all control _o (RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp, funct) 0; data fields 0.
- REQ-020: Capture: valid_o<=id_valid_i; all fields <= inputs; when id_valid_i=0 all control _o SHALL be 0.
- REQ-021: Latency exactly 1 cycle from ID inputs to _o outputs on capture.
- REQ-022: bubble_cnt_o SHALL increment by 1 on each REQ-019 or REQ-017 bubble while stall_i=0, saturating at all-ones.
- REQ-023: A held load-use (stall_i=1) SHALL not increment the counter; load_use_o remains combinationally asserted.
- REQ-024: A bubble never has RegWrite_o=1 or MemWrite_o=1.

Reset
- REQ-025: rst_i=0 SHALL immediately clear valid_o, all _o fields and bubble_cnt_o to 0, independent of clk_i.
- REQ-026: Reset deasserted mid-stall: first edge follows REQ-016 normally; load_use_o is 0 while valid_o=0.

Structure
- REQ-027: ALUOp encodings, funct width and REG_ADDR_W=5 SHALL live in the shared CPU package used by the ALU control stage.
- REQ-028: Load-use comparison SHALL be a sub-module named hazard_detect (purely combinational); pipeline registers and counter stay in id_ex_stage.

Verification
- REQ-029: Reset: rst_i=0 mid-cycle with valid_o=1 -> valid_o=0, bubble_cnt_o=0 immediately.
- REQ-030: Capture: id_valid_i=1, funct_i=4'b0111, ALUOp_i=2'b10, rd=5 -> next cycle funct_o=4'b0111, ALUOp_o=2'b10, rd_addr_o=5, valid_o=1.
- REQ-031: Load-use: EX holds lw x5 (MemRead_o=1, rd_addr_o=5), ID rs1=5 -> load_use_o=1; next cycle valid_o=0, MemRead_o=0, bubble_cnt_o=1.
- REQ-032: x0: EX lw rd_addr_o=0, ID rs1=0 -> load_use_o=0, instruction captured.
- REQ-033: Priority: flush_i=1 and stall_i=1 together -> valid_o=0, RegWrite_o=0; stall_i=1 alone -> all outputs unchanged.
- REQ-034: Saturation: preload bubble_cnt_o=16'hFFFF, force bubble -> remains 16'hFFFF.
